// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants for the register-file write-port arbiter and its result FIFO.
package rf_wb_arbiter_pkg;

  localparam int unsigned NREG_DEF       = 32;
  localparam int unsigned AW_DEF         = 5;
  localparam int unsigned DW_DEF         = 32;
  localparam int unsigned BUF_DEPTH_DEF  = 2;
  localparam int unsigned STARVE_MAX_DEF = 4;
  localparam int unsigned REG_ZERO       = 0;

endpackage

// File: rtl/wb_result_fifo.sv
// Synchronous FIFO of {rd, data} long-latency results with pass-through ready.
module wb_result_fifo #(
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [AW-1:0] push_rd_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [AW-1:0] head_rd_o,
  output logic [DW-1:0] head_data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          ready_o
);

  localparam int unsigned    PW       = $clog2(DEPTH);
  localparam logic [PW:0]    FULL_CNT = DEPTH[PW:0];

  logic [AW+DW-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW:0]      cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= {push_rd_i, push_data_i};
  end

  assign {head_rd_o, head_data_o} = mem_q[rd_ptr_q];
  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  // A pop this cycle frees a slot, so a full FIFO can still accept.
  assign ready_o = !full_o || pop_i;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between WB and buffered long-latency results,
// with starvation forcing and a pending-destination hazard scoreboard.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned NREG       = NREG_DEF,
  parameter int unsigned AW         = AW_DEF,
  parameter int unsigned DW         = DW_DEF,
  parameter int unsigned BUF_DEPTH  = BUF_DEPTH_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_waddr,
  input  logic [DW-1:0] wb_wdata,
  output logic          pipe_hold,
  input  logic          lu_issue,
  input  logic [AW-1:0] lu_issue_rd,
  input  logic          lu_valid,
  input  logic [AW-1:0] lu_rd,
  input  logic [DW-1:0] lu_data,
  output logic          lu_ready,
  input  logic [AW-1:0] dec_rs,
  input  logic [AW-1:0] dec_rt,
  input  logic [AW-1:0] dec_rd,
  output logic          hz_stall,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata
);

  localparam int unsigned    SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]  STARVE_LIM = STARVE_MAX[SW-1:0];

  logic            run_q;
  logic [SW-1:0]   starve_q, starve_d;
  logic [NREG-1:0] pend_q, pend_d;

  logic            wb_req, fifo_nonempty, starved;
  logic            grant_fifo, grant_wb, push;
  logic [AW-1:0]   head_rd;
  logic [DW-1:0]   head_data;
  logic            fifo_full, fifo_empty, fifo_ready;

  wb_result_fifo #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_rd_i   (lu_rd),
    .push_data_i (lu_data),
    .pop_i       (grant_fifo),
    .head_rd_o   (head_rd),
    .head_data_o (head_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .ready_o     (fifo_ready)
  );

  // run_q keeps the write port and lu_ready quiet until the first edge after reset.
  always_comb begin
    wb_req        = wb_we && (wb_waddr != '0);
    fifo_nonempty = !fifo_empty;
    starved       = fifo_nonempty && (starve_q == STARVE_LIM);
    grant_fifo    = run_q && fifo_nonempty && (starved || !wb_req);
    grant_wb      = run_q && wb_req && !grant_fifo;
    lu_ready      = run_q && fifo_ready;
    push          = lu_valid && lu_ready && (lu_rd != '0);
    pipe_hold     = run_q && starved;
  end

  always_comb begin
    rf_we    = grant_fifo || grant_wb;
    rf_waddr = '0;
    rf_wdata = '0;
    if (grant_fifo) begin
      rf_waddr = head_rd;
      rf_wdata = head_data;
    end else if (grant_wb) begin
      rf_waddr = wb_waddr;
      rf_wdata = wb_wdata;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!fifo_nonempty || grant_fifo) begin
      starve_d = '0;
    end else if (starve_q != STARVE_LIM) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Clear before set so a same-cycle re-issue to the draining rd stays pending.
  always_comb begin
    pend_d = pend_q;
    if (grant_fifo) pend_d[head_rd] = 1'b0;
    if (lu_issue && (lu_issue_rd != '0)) pend_d[lu_issue_rd] = 1'b1;
    pend_d[REG_ZERO] = 1'b0;
  end

  assign hz_stall = ((dec_rs != '0) && pend_q[dec_rs]) ||
                    ((dec_rt != '0) && pend_q[dec_rt]) ||
                    ((dec_rd != '0) && pend_q[dec_rd]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q    <= 1'b0;
      starve_q <= '0;
      pend_q   <= '0;
    end else begin
      run_q    <= 1'b1;
      starve_q <= starve_d;
      pend_q   <= pend_d;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        pipe_hold;
  logic        lu_issue;
  logic [4:0]  lu_issue_rd;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic [4:0]  dec_rs, dec_rt, dec_rd;
  logic        hz_stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  always #5 clk = ~clk;

  rf_wb_arbiter #(
    .NREG       (32),
    .AW         (5),
    .DW         (32),
    .BUF_DEPTH  (2),
    .STARVE_MAX (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wb_we       (wb_we),
    .wb_waddr    (wb_waddr),
    .wb_wdata    (wb_wdata),
    .pipe_hold   (pipe_hold),
    .lu_issue    (lu_issue),
    .lu_issue_rd (lu_issue_rd),
    .lu_valid    (lu_valid),
    .lu_rd       (lu_rd),
    .lu_data     (lu_data),
    .lu_ready    (lu_ready),
    .dec_rs      (dec_rs),
    .dec_rt      (dec_rt),
    .dec_rd      (dec_rd),
    .hz_stall    (hz_stall),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Reference model: results queue in arrival order, per-register pending flags.
  logic [36:0] mq[$];
  bit          pend[32];
  int          starve;
  bit          run;
  bit          last_push;

  task automatic model_reset();
    mq.delete();
    foreach (pend[i]) pend[i] = 1'b0;
    starve = 0;
    run    = 1'b0;
  endtask

  task automatic idle();
    wb_we = 0; wb_waddr = 0; wb_wdata = 0;
    lu_issue = 0; lu_issue_rd = 0;
    lu_valid = 0; lu_rd = 0; lu_data = 0;
    dec_rs = 0; dec_rt = 0; dec_rd = 0;
  endtask

  // Called just after a negedge with inputs set; checks, then advances one clock.
  task automatic step(input string tag);
    bit          wbreq, ne, forced, gfifo, gwb, rdy, stall;
    logic [4:0]  hrd, eaddr;
    logic [31:0] hd, edata;
    #1;
    wbreq  = wb_we && (wb_waddr != 0);
    ne     = (mq.size() > 0);
    forced = ne && (starve == 4);
    gfifo  = run && ne && (forced || !wbreq);
    gwb    = run && wbreq && !gfifo;
    hrd = 0; hd = 0;
    if (ne) {hrd, hd} = mq[0];
    eaddr = gfifo ? hrd : (gwb ? wb_waddr : 5'd0);
    edata = gfifo ? hd  : (gwb ? wb_wdata : 32'd0);
    rdy   = run && (mq.size() < 2 || gfifo);
    stall = (dec_rs != 0 && pend[dec_rs]) || (dec_rt != 0 && pend[dec_rt]) ||
            (dec_rd != 0 && pend[dec_rd]);
    check_eq({tag, ".rf_we"},    rf_we,     gfifo || gwb);
    check_eq({tag, ".rf_waddr"}, rf_waddr,  eaddr);
    check_eq({tag, ".rf_wdata"}, rf_wdata,  edata);
    check_eq({tag, ".hold"},     pipe_hold, run && forced);
    check_eq({tag, ".lu_ready"}, lu_ready,  rdy);
    check_eq({tag, ".hz_stall"}, hz_stall,  stall);
    @(posedge clk);
    last_push = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (gfifo) begin
        void'(mq.pop_front());
        pend[hrd] = 1'b0;
      end
      if (lu_valid && rdy && lu_rd != 0) begin
        mq.push_back({lu_rd, lu_data});
        last_push = 1'b1;
      end
      if (lu_issue && lu_issue_rd != 0) pend[lu_issue_rd] = 1'b1;
      starve = (!ne || gfifo) ? 0 : ((starve < 4) ? starve + 1 : 4);
      run = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int unsigned cycles);
    rst_n = 1'b0;
    model_reset();
    for (int unsigned i = 0; i < cycles; i++) step("rst");
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    wb_we = 1; wb_waddr = 8'd8;
    do_reset(2);
    idle();
    step("release");

    // Plain WB write goes straight through.
    wb_we = 1; wb_waddr = 5'd8; wb_wdata = 32'h1234;
    step("wb_pass");
    check_eq("wb_pass.model_state", mq.size(), 0);

    // Issue, hazard, result return and stall release.
    idle(); lu_issue = 1; lu_issue_rd = 5;
    step("issue5");
    idle(); dec_rs = 5;
    step("raw5");
    lu_valid = 1; lu_rd = 5; lu_data = 32'hDEAD;
    step("ret5");
    lu_valid = 0;
    step("drain5");
    step("clear5");

    // Starvation forcing under continuous WB.
    idle(); wb_we = 1; wb_waddr = 9; wb_wdata = 32'h99;
    lu_valid = 1; lu_rd = 3; lu_data = 32'h3333;
    step("starve_push");
    lu_valid = 0;
    for (int unsigned i = 0; i < 7; i++) begin
      wb_wdata = 32'h100 + i;
      step("starve");
    end

    // Back-to-back results during continuous WB; hold each until accepted.
    for (int unsigned r = 0; r < 3; r++) begin
      lu_valid = 1; lu_rd = 5'(10 + r); lu_data = 32'hA000 + r;
      for (int unsigned t = 0; t < 10; t++) begin
        step("b2b");
        if (last_push) break;
      end
    end
    lu_valid = 0;
    for (int unsigned i = 0; i < 12; i++) step("b2b_drain");
    wb_we = 0;
    for (int unsigned i = 0; i < 3; i++) step("b2b_idle");

    // Register-zero corner cases.
    idle(); lu_valid = 1; lu_rd = 7; lu_data = 32'h77;
    step("z_push");
    idle(); wb_we = 1; wb_waddr = 0; wb_wdata = 32'hBAD;
    step("z_wb0");
    idle(); lu_valid = 1; lu_rd = 0; lu_data = 32'hBAD0;
    step("z_lu0");
    idle(); lu_issue = 1; lu_issue_rd = 0;
    step("z_issue0");
    idle(); dec_rs = 0;
    step("z_dec0");
    check_eq("z_dec0.model_empty", mq.size(), 0);

    // Reset mid-drain with two buffered entries.
    idle(); wb_we = 1; wb_waddr = 2; lu_issue = 1; lu_issue_rd = 13;
    lu_valid = 1; lu_rd = 13; lu_data = 32'hD13;
    step("mr_a");
    lu_issue_rd = 14; lu_rd = 14; lu_data = 32'hD14;
    step("mr_b");
    idle(); dec_rs = 14;
    step("mr_drain");
    wb_we = 1; wb_waddr = 4;
    do_reset(2);
    idle(); dec_rs = 14;
    for (int unsigned i = 0; i < 4; i++) step("mr_after");

    // Random traffic with occasional resets.
    for (int unsigned c = 0; c < 3000; c++) begin
      wb_we       = ($urandom_range(0, 3) != 0);
      wb_waddr    = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      wb_wdata    = $urandom;
      lu_issue    = ($urandom_range(0, 3) == 0);
      lu_issue_rd = 5'($urandom_range(0, 7));
      lu_valid    = ($urandom_range(0, 2) == 0);
      lu_rd       = 5'($urandom_range(0, 7));
      lu_data     = $urandom;
      dec_rs      = 5'($urandom_range(0, 7));
      dec_rt      = 5'($urandom_range(0, 7));
      dec_rd      = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 299) == 0) do_reset(1);
      else step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
